// File: rtl/gpio_input_debouncer.sv
// gpio_input_debouncer
// Conditions raw board pins before they reach the rvx gpio_input bus.
// Each bit passes through a 2-flop synchronizer and then a stability
// counter; the debounced output only follows the pin once the pin has held
// a new level for D consecutive synchronized samples, where
// D = (CLOCK_FREQUENCY/1000000)*DEBOUNCE_TIME_US (minimum 1).
//
// Optional feature macro: GPIO_DEBOUNCE_EDGE_EN
//   defined   -> registered one-cycle rise/fall pulses per bit
//   undefined -> rise_pulse/fall_pulse tied to 0, no pulse registers
// The port list and gpio_debounced behaviour are identical in both builds.
module gpio_input_debouncer #(
  parameter int                    GPIO_WIDTH       = 3,
  parameter int                    CLOCK_FREQUENCY  = 12000000,
  parameter int                    DEBOUNCE_TIME_US = 10000,
  parameter logic [GPIO_WIDTH-1:0] RESET_VALUE      = '0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [GPIO_WIDTH-1:0] gpio_raw,
  output logic [GPIO_WIDTH-1:0] gpio_debounced,
  output logic [GPIO_WIDTH-1:0] rise_pulse,
  output logic [GPIO_WIDTH-1:0] fall_pulse
);

  // Debounce length in clock cycles; a zero product still needs one sample.
  localparam int D_RAW = (CLOCK_FREQUENCY / 1000000) * DEBOUNCE_TIME_US;
  localparam int D     = (D_RAW < 1) ? 1 : D_RAW;
  localparam int CNT_W = (D < 1) ? 1 : $clog2(D + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(D - 1);

  logic [GPIO_WIDTH-1:0] sync1_reg;
  logic [GPIO_WIDTH-1:0] sync2_reg;
  logic [GPIO_WIDTH-1:0] deb_reg;
  logic [GPIO_WIDTH-1:0] deb_next;

  // Two-flop synchronizer; only sync2 is allowed to feed the debounce logic.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_reg <= RESET_VALUE;
      sync2_reg <= RESET_VALUE;
    end else begin
      sync1_reg <= gpio_raw;
      sync2_reg <= sync1_reg;
    end
  end

  // One fully independent stability counter per bit.
  generate
    for (genvar gi = 0; gi < GPIO_WIDTH; gi++) begin : g_bit
      logic [CNT_W-1:0] cnt_reg;
      logic [CNT_W-1:0] cnt_next;
      logic             bit_next;

      // Any sample agreeing with the output restarts the count; the D-th
      // consecutive disagreeing sample commits the new level.
      always_comb begin
        cnt_next = cnt_reg;
        bit_next = deb_reg[gi];
        if (sync2_reg[gi] == deb_reg[gi]) begin
          cnt_next = '0;
        end else if (cnt_reg == CNT_LAST) begin
          bit_next = sync2_reg[gi];
          cnt_next = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      // Counter state; reset discards any partial progress.
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          cnt_reg <= '0;
        end else begin
          cnt_reg <= cnt_next;
        end
      end

      assign deb_next[gi] = bit_next;
    end
  endgenerate

  // Debounced output register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      deb_reg <= RESET_VALUE;
    end else begin
      deb_reg <= deb_next;
    end
  end

  assign gpio_debounced = deb_reg;

`ifdef GPIO_DEBOUNCE_EDGE_EN
  logic [GPIO_WIDTH-1:0] rise_reg;
  logic [GPIO_WIDTH-1:0] fall_reg;

  // Pulses are registered alongside the output so they are high for exactly
  // the cycle in which the new debounced level first appears.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rise_reg <= '0;
      fall_reg <= '0;
    end else begin
      rise_reg <= deb_next & ~deb_reg;
      fall_reg <= ~deb_next & deb_reg;
    end
  end

  assign rise_pulse = rise_reg;
  assign fall_pulse = fall_reg;
`else
  assign rise_pulse = '0;
  assign fall_pulse = '0;
`endif

endmodule

// File: tb/tb_gpio_input_debouncer.sv
// tb_gpio_input_debouncer
// Drives directed and random pin patterns into gpio_input_debouncer with
// D = 4 and compares every cycle against a sliding-window reference: a bit
// flips at edge m when the last D synchronized samples (pin values captured
// at edges m-1-D .. m-2) all differ from the current output.
module tb_gpio_input_debouncer;

  localparam int W     = 3;
  localparam int CF    = 1000000;
  localparam int DT    = 4;
  localparam int D_RAW = (CF / 1000000) * DT;
  localparam int D     = (D_RAW < 1) ? 1 : D_RAW;
  localparam logic [W-1:0] RV = '0;
`ifdef GPIO_DEBOUNCE_EDGE_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic         clock;
  logic         reset_n;
  logic [W-1:0] gpio_raw;
  logic [W-1:0] gpio_debounced;
  logic [W-1:0] rise_pulse;
  logic [W-1:0] fall_pulse;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [W-1:0] m_deb;
  logic [W-1:0] m_rise;
  logic [W-1:0] m_fall;
  logic [W-1:0] samp[$];

  gpio_input_debouncer #(
    .GPIO_WIDTH      (W),
    .CLOCK_FREQUENCY (CF),
    .DEBOUNCE_TIME_US(DT),
    .RESET_VALUE     (RV)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .gpio_raw      (gpio_raw),
    .gpio_debounced(gpio_debounced),
    .rise_pulse    (rise_pulse),
    .fall_pulse    (fall_pulse)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%b exp=%b", tag, $time, got, exp);
    end
  endtask

  // Model reset: history before the first edge looks like the reset value.
  task automatic model_reset();
    samp.delete();
    for (int i = 0; i < D + 2; i++) samp.push_back(RV);
    m_deb  = RV;
    m_rise = '0;
    m_fall = '0;
  endtask

  // Model one clock edge with pin value r sampled at that edge.
  task automatic model_edge(input logic [W-1:0] r);
    logic [W-1:0] nxt;
    logic         all_diff;
    samp.push_back(r);
    if (samp.size() > D + 3) void'(samp.pop_front());
    nxt = m_deb;
    for (int b = 0; b < W; b++) begin
      all_diff = 1'b1;
      for (int j = 1; j <= D; j++) begin
        if (samp[j][b] == m_deb[b]) all_diff = 1'b0;
      end
      if (all_diff) nxt[b] = ~m_deb[b];
    end
    m_rise = EDGE_EN ? (nxt & ~m_deb) : '0;
    m_fall = EDGE_EN ? (~nxt & m_deb) : '0;
    m_deb  = nxt;
  endtask

  // Apply one pin value for one clock edge and compare afterwards.
  task automatic cycle(input logic [W-1:0] r);
    gpio_raw = r;
    @(posedge clock);
    model_edge(r);
    #1;
    check("debounced", gpio_debounced, m_deb);
    check("rise", rise_pulse, m_rise);
    check("fall", fall_pulse, m_fall);
    $display("edge t=%0t raw=%b deb=%b rise=%b fall=%b", $time, r, gpio_debounced, rise_pulse, fall_pulse);
  endtask

  task automatic hold(input logic [W-1:0] r, input int n);
    for (int i = 0; i < n; i++) cycle(r);
  endtask

  initial begin
    logic [W-1:0] v;
    int           len;

    // 1: reset with pins high, outputs must be reset value with no clock edge
    reset_n  = 1'b0;
    gpio_raw = 3'b111;
    #2;
    check("reset_deb", gpio_debounced, RV);
    check("reset_rise", rise_pulse, '0);
    check("reset_fall", fall_pulse, '0);
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
    hold(3'b111, D + 4);

    // 2: single bit step with other bits held
    hold(3'b101, D + 4);
    hold(3'b111, D + 4);

    // 3: short pulse below D is swallowed, D-long pulse gets through
    hold(3'b011, D + 3);
    hold(3'b111, D - 1);
    hold(3'b011, D + 3);
    hold(3'b111, D);
    hold(3'b011, D + 4);

    // 4: bit 0 chatters every 2 cycles, then settles high
    hold(3'b010, D + 3);
    for (int i = 0; i < 10; i++) hold((i % 2 == 0) ? 3'b011 : 3'b010, 2);
    hold(3'b011, D + 4);

    // 5: bit 0 falls and bit 1 rises on the same edge
    hold(3'b001, D + 3);
    hold(3'b010, D + 4);

    // 6: asynchronous reset in the middle of a count
    hold(3'b000, D + 4);
    hold(3'b010, 4);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_deb", gpio_debounced, RV);
    check("async_rise", rise_pulse, '0);
    check("async_fall", fall_pulse, '0);
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
    hold(3'b010, D + 4);

    // Random segments of random length, including sub-D glitches
    for (int s = 0; s < 250; s++) begin
      v   = W'($urandom);
      len = $urandom_range(1, 2 * D);
      hold(v, len);
    end

    // Random mid-run reset followed by more random activity
    hold(3'b111, 3);
    #2;
    reset_n = 1'b0;
    #1;
    check("async2_deb", gpio_debounced, RV);
    @(negedge clock);
    reset_n = 1'b1;
    model_reset();
    for (int s = 0; s < 100; s++) begin
      v   = W'($urandom);
      len = $urandom_range(1, 2 * D);
      hold(v, len);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
